// File: rtl/swap_req_sequencer_pkg.sv
// rtl/swap_req_sequencer_pkg.sv - shared swap control state encoding and write-phase length
package swap_req_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } swap_state_e;

  // The downstream datapath spends this many cycles writing after the start pulse.
  localparam logic [1:0] WAIT_LEN = 2'd3;

endpackage

// File: rtl/swap_req_fifo.sv
// rtl/swap_req_fifo.sv - request queue holding address pairs in arrival order
module swap_req_fifo #(
  parameter int address_width = 7,
  parameter int depth         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [address_width-1:0]   push_a,
  input  logic [address_width-1:0]   push_b,
  input  logic                       pop,
  output logic [address_width-1:0]   head_a,
  output logic [address_width-1:0]   head_b,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int PW = $clog2(depth);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(depth);

  logic [address_width-1:0] mem_a [depth];
  logic [address_width-1:0] mem_b [depth];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_a  = mem_a[rd_ptr];
  assign head_b  = mem_b[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_a[wr_ptr] <= push_a;
      mem_b[wr_ptr] <= push_b;
    end
  end

endmodule

// File: rtl/swap_req_sequencer.sv
// rtl/swap_req_sequencer.sv - queues swap requests and sequences them onto the swap datapath
module swap_req_sequencer
  import swap_req_sequencer_pkg::*;
#(
  parameter int address_width = 7,
  parameter int depth         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [address_width-1:0]   req_addr_a,
  input  logic [address_width-1:0]   req_addr_b,
  output logic                       swap,
  output logic [address_width-1:0]   address_a,
  output logic [address_width-1:0]   address_b,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(depth):0]     count
);

  swap_state_e              state, state_d;
  logic [1:0]               wait_cnt, wait_cnt_d;
  logic [address_width-1:0] addr_a_d, addr_b_d;
  logic [address_width-1:0] head_a, head_b;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  swap_req_fifo #(
    .address_width (address_width),
    .depth         (depth)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .push_a (req_addr_a),
    .push_b (req_addr_b),
    .pop    (pop),
    .head_a (head_a),
    .head_b (head_b),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      address_a <= '0;
      address_b <= '0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      address_a <= addr_a_d;
      address_b <= addr_b_d;
    end
  end

  // Addresses only load on a pop, so they stay put from ISSUE through DONE.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    addr_a_d   = address_a;
    addr_b_d   = address_b;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          addr_a_d = head_a;
          addr_b_d = head_b;
          state_d  = (head_a == head_b) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = WAIT_LEN;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt - 2'd1;
        if (wait_cnt == 2'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign swap = (state == ISSUE);
  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_swap_req_sequencer.sv
// tb/tb_swap_req_sequencer.sv - directed self-checking bench for swap_req_sequencer
module tb_swap_req_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr_a;
  logic [6:0] req_addr_b;
  logic       swap;
  logic [6:0] address_a;
  logic [6:0] address_b;
  logic       busy;
  logic       done;
  logic [2:0] count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int swap_a_log[$];
  int swap_cyc_log[$];

  logic [7:0] mem [128];
  logic [7:0] exp_mem [128];
  logic [7:0] dp_tmp;
  logic [6:0] dp_a, dp_b;
  int         dp_phase = 0;

  swap_req_sequencer #(.address_width(7), .depth(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .swap       (swap),
    .address_a  (address_a),
    .address_b  (address_b),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (swap) begin
        swap_a_log.push_back(int'(address_a));
        swap_cyc_log.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  // Behavioural swap datapath: read, write a, write b over the three wait cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_phase = 0;
    else if (swap) begin
      dp_a = address_a; dp_b = address_b; dp_phase = 1;
    end else if (dp_phase == 1) begin
      dp_tmp = mem[dp_a]; dp_phase = 2;
    end else if (dp_phase == 2) begin
      mem[dp_a] = mem[dp_b]; dp_phase = 3;
    end else if (dp_phase == 3) begin
      mem[dp_b] = dp_tmp; dp_phase = 0;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int a, input int b);
    req_addr_a = 7'(a);
    req_addr_b = 7'(b);
    req_valid  = 1'b1;
    for (int k = 0; k < 30 && !req_ready; k++) step();
    check("push_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60 && !done; k++) step();
    check(tag, done, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && (busy || count != 0); k++) step();
    check("idle_reached", {busy, count}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0;
    step(); step();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_swap", swap, 0);
    check("rst_done", done, 0);
    check("rst_addr_a", address_a, 0);
    rst_n = 1'b1;
    step();
    check("rst_ready", req_ready, 1);

    // Single request a=5 b=9.
    swap_a_log.delete(); done_cnt = 0;
    push_one(5, 9);
    check("s_count_e0", count, 1);
    check("s_busy_e0", busy, 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("s_swap_c%0d", c), swap, (c == 1) ? 1 : 0);
      check($sformatf("s_done_c%0d", c), done, (c == 5) ? 1 : 0);
      check($sformatf("s_busy_c%0d", c), busy, (c <= 5) ? 1 : 0);
      if (c <= 5) check($sformatf("s_addr_c%0d", c), {address_a, address_b}, {7'd5, 7'd9});
    end
    check("s_swap_once", swap_a_log.size(), 1);

    // a == b: no swap, done in the cycle after the pop.
    wait_idle();
    swap_a_log.delete();
    push_one(12, 12);
    check("eq_done_e0", done, 0);
    step();
    check("eq_done_e1", done, 1);
    check("eq_swap_e1", swap, 0);
    check("eq_addr_e1", address_a, 12);
    step();
    check("eq_done_e2", done, 0);
    check("eq_busy_e2", busy, 0);
    check("eq_no_swap", swap_a_log.size(), 0);

    // Fill to depth while the first request is in flight; 5th waits for a pop.
    wait_idle();
    swap_a_log.delete(); swap_cyc_log.delete();
    push_one(1, 2);
    push_one(10, 3);
    check("f_count1", count, 1);
    push_one(11, 3);
    push_one(12, 3);
    push_one(13, 3);
    check("f_count4", count, 4);
    check("f_ready_full", req_ready, 0);
    req_addr_a = 7'd14; req_addr_b = 7'd3; req_valid = 1'b1;
    step();
    check("f_hold_e5", count, 4);
    step();
    check("f_hold_e6", count, 4);
    check("f_ready_e6", req_ready, 0);
    step();
    check("f_pop_e7", count, 3);
    check("f_ready_e7", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("f_push5_e8", count, 4);
    wait_idle();
    check("f_log_len", swap_a_log.size(), 6);
    if (swap_a_log.size() == 6) begin
      check("f_order0", swap_a_log[0], 1);
      for (int i = 1; i < 6; i++) begin
        check($sformatf("f_order%0d", i), swap_a_log[i], 9 + i);
        check($sformatf("f_period%0d", i), swap_cyc_log[i] - swap_cyc_log[i-1], 6);
      end
    end

    // Push in the same cycle as a pop with count = 2.
    swap_a_log.delete();
    push_one(20, 1);
    push_one(22, 1);
    push_one(24, 1);
    check("pp_count2", count, 2);
    wait_done("pp_done");
    step();
    check("pp_idle_count", count, 2);
    check("pp_idle_busy", busy, 0);
    req_addr_a = 7'd26; req_addr_b = 7'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("pp_same_cycle", count, 2);
    check("pp_busy", busy, 1);
    wait_idle();
    check("pp_log_len", swap_a_log.size(), 4);
    if (swap_a_log.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("pp_order%0d", i), swap_a_log[i], 20 + 2 * i);

    // Reset asserted in WAIT with two entries queued.
    push_one(30, 31);
    push_one(32, 33);
    push_one(34, 35);
    check("r_pre_busy", busy, 1);
    check("r_pre_swap", swap, 0);
    check("r_pre_count", count, 2);
    rst_n = 1'b0;
    #1;
    check("r_swap", swap, 0);
    check("r_done", done, 0);
    check("r_busy", busy, 0);
    check("r_count", count, 0);
    check("r_addr", {address_a, address_b}, 0);
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    check("r_ready", req_ready, 1);
    for (int k = 0; k < 15; k++) step();
    check("r_no_done", done_cnt, 0);
    check("r_no_busy", busy, 0);

    // Random requests against the behavioural datapath.
    for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];
    for (int n = 0; n < 8; n++) begin
      int a, b;
      logic [7:0] t;
      a = $urandom_range(0, 127);
      b = (n == 3) ? a : $urandom_range(0, 127);
      t = exp_mem[a]; exp_mem[a] = exp_mem[b]; exp_mem[b] = t;
      push_one(a, b);
      wait_done($sformatf("rnd_done%0d", n));
      check($sformatf("rnd_addr%0d", n), {address_a, address_b}, {7'(a), 7'(b)});
      check($sformatf("rnd_mem_a%0d", n), mem[a], exp_mem[a]);
      check($sformatf("rnd_mem_b%0d", n), mem[b], exp_mem[b]);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
